sha1_pad: RTL and testbench

SHA1_PAD -- requirements
Module: sha1_pad

---
 rtl/sha1_pad.sv | 174 +++++++++++++++++
 tb/tb_sha1_pad.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha1_pad.sv
// SHA-1 message padder: packs a byte stream into 512-bit blocks, appends the 0x80
// marker, zero fill and the 64-bit bit length, and streams each block to a SHA-1 core.
module sha1_pad #(
  parameter int LEN_W = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        core_rdy,
  input  logic        core_done,
  output logic [31:0] core_msg,
  output logic        core_write_en,
  output logic        blk_last,
  output logic        busy
);

  typedef enum logic [2:0] {
    FILL      = 3'd0,
    PAD       = 3'd1,
    WAIT_RDY  = 3'd2,
    SEND      = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  // Byte k of the block lives at [511-8k -: 8], so word w is [511-32w -: 32].
  logic [511:0]       buf_q, buf_d;
  logic [6:0]         pos_q, pos_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               pad_pend_q, pad_pend_d;
  logic               len_pend_q, len_pend_d;
  logic               final_q, final_d;
  logic [3:0]         word_q, word_d;
  logic               in_ready_q;
  logic [63:0]        len64_s;

  always_comb begin
    len64_s              = 64'd0;
    len64_s[LEN_W-1:0]   = len_q;
  end

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    pos_d      = pos_q;
    len_d      = len_q;
    pad_pend_d = pad_pend_q;
    len_pend_d = len_pend_q;
    final_d    = final_q;
    word_d     = word_q;
    case (state_q)
      FILL: begin
        if (in_valid && in_ready_q) begin
          buf_d[511 - 8*int'(pos_q[5:0]) -: 8] = in_data;
          pos_d = pos_q + 7'd1;
          len_d = len_q + LEN_W'(8);
          if (in_last) begin
            pad_pend_d = 1'b1;
            state_d    = PAD;
          end else if (pos_q == 7'd63) begin
            final_d = 1'b0;
            state_d = WAIT_RDY;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = FILL;
        end
      end
      PAD: begin
        if (pad_pend_q && (pos_q < 7'd64)) begin
          for (int k = 0; k < 64; k++) begin
            if (k > int'(pos_q)) begin
              buf_d[511 - 8*k -: 8] = 8'h00;
            end else if (k == int'(pos_q)) begin
              buf_d[511 - 8*k -: 8] = 8'h80;
            end else begin
              buf_d[511 - 8*k -: 8] = buf_q[511 - 8*k -: 8];
            end
          end
          pad_pend_d = 1'b0;
          if (pos_q <= 7'd55) begin
            buf_d[63:0] = len64_s;
            len_pend_d  = 1'b0;
            final_d     = 1'b1;
          end else begin
            len_pend_d = 1'b1;
            final_d    = 1'b0;
          end
        end else if (pad_pend_q) begin
          // Final byte filled the block: marker and length go into the next one.
          len_pend_d = 1'b1;
          final_d    = 1'b0;
        end else begin
          buf_d[63:0] = len64_s;
          len_pend_d  = 1'b0;
          final_d     = 1'b1;
        end
        state_d = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (core_rdy) begin
          word_d  = 4'd0;
          state_d = SEND;
        end else begin
          state_d = WAIT_RDY;
        end
      end
      SEND: begin
        if (word_q == 4'd15) begin
          buf_d   = 512'd0;
          pos_d   = 7'd0;
          word_d  = 4'd0;
          state_d = WAIT_DONE;
        end else begin
          word_d  = word_q + 4'd1;
          state_d = SEND;
        end
      end
      WAIT_DONE: begin
        if (core_done) begin
          if (pad_pend_q || len_pend_q) begin
            state_d = PAD;
          end else if (final_q) begin
            len_d   = {LEN_W{1'b0}};
            state_d = FILL;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = WAIT_DONE;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      buf_q      <= 512'd0;
      pos_q      <= 7'd0;
      len_q      <= {LEN_W{1'b0}};
      pad_pend_q <= 1'b0;
      len_pend_q <= 1'b0;
      final_q    <= 1'b0;
      word_q     <= 4'd0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      pos_q      <= pos_d;
      len_q      <= len_d;
      pad_pend_q <= pad_pend_d;
      len_pend_q <= len_pend_d;
      final_q    <= final_d;
      word_q     <= word_d;
      in_ready_q <= (state_d == FILL);
    end
  end

  assign in_ready      = in_ready_q;
  assign core_write_en = (state_q == SEND);
  assign core_msg      = (state_q == SEND) ? buf_q[511 - 32*int'(word_q) -: 32] : 32'd0;
  assign blk_last      = (state_q == SEND) && final_q;
  assign busy          = (state_q != FILL);

endmodule

// File: tb/tb_sha1_pad.sv
// Self-checking bench for sha1_pad: a padding reference model fills a scoreboard of
// expected {blk_last, word} entries that are matched against the words the DUT emits.
module tb_sha1_pad;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        core_rdy = 1'b1;
  logic        core_done;
  logic [31:0] core_msg;
  logic        core_write_en;
  logic        blk_last;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];
  logic [32:0] obs_q[$];
  logic [7:0]  msg[$];

  always #5 clk = ~clk;

  sha1_pad #(.LEN_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .core_rdy(core_rdy), .core_done(core_done), .core_msg(core_msg),
    .core_write_en(core_write_en), .blk_last(blk_last), .busy(busy)
  );

  // Core model: pulse core_done a few cycles after each 16-word burst ends.
  logic prev_we;
  int   done_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_we   <= 1'b0;
      done_cnt  <= 0;
      core_done <= 1'b0;
    end else begin
      prev_we   <= core_write_en;
      core_done <= (done_cnt == 1);
      if (prev_we && !core_write_en) done_cnt <= 3;
      else if (done_cnt > 0) done_cnt <= done_cnt - 1;
    end
  end

  always @(negedge clk) begin
    if (core_write_en) obs_q.push_back({blk_last, core_msg});
  end

  task automatic load_str(input string s);
    msg.delete();
    for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
  endtask

  task automatic push_model();
    logic [7:0]  p[$];
    logic [63:0] bl;
    int          nb;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(msg.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++)
      for (int w = 0; w < 16; w++)
        exp_q.push_back({(b == nb - 1), p[b*64+4*w], p[b*64+4*w+1], p[b*64+4*w+2], p[b*64+4*w+3]});
  endtask

  task automatic push_abc();
    exp_q.push_back({1'b1, 32'h61626380});
    for (int w = 1; w < 15; w++) exp_q.push_back({1'b1, 32'h00000000});
    exp_q.push_back({1'b1, 32'h00000018});
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      checks++;
      errors++;
      $display("FAIL send_byte in_ready timeout got 0 exp 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    in_last  = 1'($urandom);
  endtask

  task automatic send_msg();
    for (int i = 0; i < msg.size(); i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send_byte(msg[i], (i == msg.size() - 1));
    end
  endtask

  task automatic wait_out(input string name);
    int t = 0;
    while ((obs_q.size() < exp_q.size() || !in_ready) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 5000) begin
      errors++;
      $display("FAIL %s timeout got %0d words exp %0d", name, obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, core_write_en, blk_last, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0000", {in_ready, core_write_en, blk_last, busy});
    end
    checks++;
    if (core_msg !== 32'd0) begin
      errors++;
      $display("FAIL reset_msg got %h exp 00000000", core_msg);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_early got %b exp 0", in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_rise got %b exp 1", in_ready);
    end
  endtask

  task automatic test_abc();
    logic [32:0] e, o;
    push_abc();
    load_str("abc");
    send_msg();
    wait_out("abc");
    for (int n = 0; exp_q.size() > 0; n++) begin
      e = exp_q.pop_front();
      o = 'x;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL abc word%0d got %h exp %h", n, o, e);
      end
    end
  endtask

  task automatic test_alnum();
    logic [32:0] e, o;
    load_str("abcdefghijklmnopqrstuvwxyz0123456789");
    push_model();
    send_msg();
    wait_out("alnum");
    for (int n = 0; exp_q.size() > 0; n++) begin
      e = exp_q.pop_front();
      o = 'x;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL alnum word%0d got %h exp %h", n, o, e);
      end
    end
  endtask

  task automatic test_boundary();
    logic [32:0] e, o;
    int lens[3] = '{55, 56, 64};
    foreach (lens[j]) begin
      msg.delete();
      for (int i = 0; i < lens[j]; i++) msg.push_back(8'h61);
      push_model();
      send_msg();
      wait_out("boundary");
      for (int n = 0; exp_q.size() > 0; n++) begin
        e = exp_q.pop_front();
        o = 'x;
        if (obs_q.size() > 0) o = obs_q.pop_front();
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL boundary%0d word%0d got %h exp %h", lens[j], n, o, e);
        end
      end
    end
  endtask

  task automatic test_hello();
    logic [32:0] e, o;
    string s = "hello";
    for (int i = 0; i < 109; i++) s = {s, " "};
    s = {s, "world"};
    load_str(s);
    push_model();
    send_msg();
    wait_out("hello");
    for (int n = 0; exp_q.size() > 0; n++) begin
      e = exp_q.pop_front();
      o = 'x;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL hello word%0d got %h exp %h", n, o, e);
      end
    end
  endtask

  task automatic test_stall();
    logic [32:0] e, o;
    core_rdy = 1'b0;
    push_abc();
    load_str("abc");
    send_msg();
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      checks++;
      if (core_write_en !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc%0d got we=%b rdy=%b exp 0 0", c, core_write_en, in_ready);
      end
    end
    core_rdy = 1'b1;
    #1;
    checks++;
    if (core_write_en !== 1'b0) begin
      errors++;
      $display("FAIL stall_early got %b exp 0", core_write_en);
    end
    @(negedge clk);
    checks++;
    if (core_write_en !== 1'b1) begin
      errors++;
      $display("FAIL stall_start got %b exp 1", core_write_en);
    end
    wait_out("stall");
    for (int n = 0; exp_q.size() > 0; n++) begin
      e = exp_q.pop_front();
      o = 'x;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL stall word%0d got %h exp %h", n, o, e);
      end
    end
  endtask

  task automatic test_reset_mid_send();
    logic [32:0] e, o;
    int t = 0;
    load_str("xyz");
    send_msg();
    while (obs_q.size() < 8 && t < 500) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 500) begin
      errors++;
      $display("FAIL midrst_reach got %0d words exp 8", obs_q.size());
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({core_write_en, busy, core_msg} !== 34'd0) begin
      errors++;
      $display("FAIL midrst_drop got we=%b busy=%b msg=%h exp 0 0 0", core_write_en, busy, core_msg);
    end
    obs_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_abc();
    load_str("abc");
    send_msg();
    wait_out("midrst");
    for (int n = 0; exp_q.size() > 0; n++) begin
      e = exp_q.pop_front();
      o = 'x;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL midrst word%0d got %h exp %h", n, o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] e, o;
    msg.delete();
    msg.push_back(8'h01);
    msg.push_back(8'h02);
    msg.push_back(8'h03);
    push_model();
    send_msg();
    msg.delete();
    for (int i = 0; i < 70; i++) msg.push_back(8'($urandom));
    push_model();
    send_msg();
    wait_out("b2b");
    for (int n = 0; exp_q.size() > 0; n++) begin
      e = exp_q.pop_front();
      o = 'x;
      if (obs_q.size() > 0) o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL b2b word%0d got %h exp %h", n, o, e);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_extra got %0d words exp 0", obs_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_alnum();
    test_boundary();
    test_hello();
    test_stall();
    test_reset_mid_send();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
